// File: rtl/min_pair_scan.sv
// Sequential two-minimum finder: scans the symbol-count table one entry per cycle,
// skipping retired entries, and returns the two smallest counts with their addresses.
module min_pair_scan #(
    parameter int N_ENTRY = 6,
    parameter int CNT_W   = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [N_ENTRY-1:0] active,
    output logic [2:0]         addr,
    input  logic [CNT_W-1:0]   rd_data,
    output logic [CNT_W-1:0]   mini1,
    output logic [CNT_W-1:0]   mini2,
    output logic [2:0]         idx1,
    output logic [2:0]         idx2,
    output logic               pair_ok,
    output logic               busy,
    output logic               done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_LAST = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [2:0] LAST_ADDR = 3'(N_ENTRY - 1);

    logic [1:0]       state_reg;
    logic [2:0]       addr_reg;
    logic [7:0]       act_q_reg;
    logic [1:0]       nf_reg, nf_next;
    logic [CNT_W-1:0] mini1_reg, mini1_next;
    logic [CNT_W-1:0] mini2_reg, mini2_next;
    logic [2:0]       idx1_reg, idx1_next;
    logic [2:0]       idx2_reg, idx2_next;
    logic             pair_ok_reg;

    logic             cmp_en;
    logic [2:0]       entry;

    // rd_data always belongs to the address presented one cycle earlier, so in READ
    // the compared entry lags addr by one; in LAST addr is held on the final entry.
    always_comb begin
        cmp_en     = ((state_reg == ST_READ) && (addr_reg != 3'd0)) || (state_reg == ST_LAST);
        entry      = (state_reg == ST_LAST) ? addr_reg : addr_reg - 3'd1;
        nf_next    = nf_reg;
        mini1_next = mini1_reg;
        mini2_next = mini2_reg;
        idx1_next  = idx1_reg;
        idx2_next  = idx2_reg;
        if (cmp_en && act_q_reg[entry]) begin
            case (nf_reg)
                2'd0: begin
                    mini1_next = rd_data;
                    idx1_next  = entry;
                    nf_next    = 2'd1;
                end
                2'd1: begin
                    if (rd_data < mini1_reg) begin
                        mini2_next = mini1_reg;
                        idx2_next  = idx1_reg;
                        mini1_next = rd_data;
                        idx1_next  = entry;
                    end else begin
                        mini2_next = rd_data;
                        idx2_next  = entry;
                    end
                    nf_next = 2'd2;
                end
                default: begin
                    // Strict compares keep the earlier (lower) address on ties.
                    if (rd_data < mini1_reg) begin
                        mini2_next = mini1_reg;
                        idx2_next  = idx1_reg;
                        mini1_next = rd_data;
                        idx1_next  = entry;
                    end else if (rd_data < mini2_reg) begin
                        mini2_next = rd_data;
                        idx2_next  = entry;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            addr_reg    <= 3'd0;
            act_q_reg   <= 8'd0;
            nf_reg      <= 2'd0;
            mini1_reg   <= '0;
            mini2_reg   <= '0;
            idx1_reg    <= 3'd0;
            idx2_reg    <= 3'd0;
            pair_ok_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    addr_reg <= 3'd0;
                    if (start) begin
                        act_q_reg   <= 8'(active);
                        nf_reg      <= 2'd0;
                        mini1_reg   <= '0;
                        mini2_reg   <= '0;
                        idx1_reg    <= 3'd0;
                        idx2_reg    <= 3'd0;
                        pair_ok_reg <= 1'b0;
                        state_reg   <= ST_READ;
                    end
                end
                ST_READ: begin
                    nf_reg    <= nf_next;
                    mini1_reg <= mini1_next;
                    mini2_reg <= mini2_next;
                    idx1_reg  <= idx1_next;
                    idx2_reg  <= idx2_next;
                    if (addr_reg == LAST_ADDR) begin
                        state_reg <= ST_LAST;
                    end else begin
                        addr_reg <= addr_reg + 3'd1;
                    end
                end
                ST_LAST: begin
                    nf_reg      <= nf_next;
                    mini1_reg   <= mini1_next;
                    mini2_reg   <= mini2_next;
                    idx1_reg    <= idx1_next;
                    idx2_reg    <= idx2_next;
                    pair_ok_reg <= (nf_next == 2'd2);
                    addr_reg    <= 3'd0;
                    state_reg   <= ST_DONE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign addr    = addr_reg;
    assign mini1   = mini1_reg;
    assign mini2   = mini2_reg;
    assign idx1    = idx1_reg;
    assign idx2    = idx2_reg;
    assign pair_ok = pair_ok_reg;
    assign busy    = (state_reg != ST_IDLE);
    assign done    = (state_reg == ST_DONE);

endmodule

// File: tb/tb_min_pair_scan.sv
// Bench for min_pair_scan: directed scenarios plus random scans, checked against a
// sort-based reference (two smallest by value, then by address, among active entries).
module tb_min_pair_scan;

    localparam int N = 6;
    localparam int W = 6;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] active;
    logic [2:0]   addr;
    logic [W-1:0] rd_data;
    logic [W-1:0] mini1, mini2;
    logic [2:0]   idx1, idx2;
    logic         pair_ok, busy, done;

    logic [W-1:0] mem [0:7];
    int errors = 0;
    int checks = 0;

    min_pair_scan #(.N_ENTRY(N), .CNT_W(W)) dut (
        .clk(clk), .reset(reset), .start(start), .active(active), .addr(addr),
        .rd_data(rd_data), .mini1(mini1), .mini2(mini2), .idx1(idx1), .idx2(idx2),
        .pair_ok(pair_ok), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Count table with one-cycle read latency.
    always @(posedge clk) rd_data <= mem[addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: pick the (value,address)-smallest active entry, then the next one.
    task automatic model(input logic [N-1:0] mask, output logic [W-1:0] m1, output logic [2:0] i1,
                         output logic [W-1:0] m2, output logic [2:0] i2, output logic ok);
        int cnt = 0;
        int b1 = -1;
        int b2 = -1;
        for (int j = 0; j < N; j++)
            if (mask[j]) begin
                cnt++;
                if (b1 < 0 || mem[j] < mem[b1]) b1 = j;
            end
        for (int j = 0; j < N; j++)
            if (mask[j] && j != b1 && (b2 < 0 || mem[j] < mem[b2])) b2 = j;
        m1 = (b1 < 0) ? '0 : mem[b1];
        i1 = (b1 < 0) ? 3'd0 : 3'(b1);
        m2 = (b2 < 0) ? '0 : mem[b2];
        i2 = (b2 < 0) ? 3'd0 : 3'(b2);
        ok = (cnt >= 2);
    endtask

    // Called in an IDLE cycle; returns in the cycle after done (IDLE again).
    task automatic scan(input logic [N-1:0] mask, input bit disturb, input string name);
        logic [W-1:0] em1, em2;
        logic [2:0]   ei1, ei2;
        logic         eok;
        int           cyc;
        model(mask, em1, ei1, em2, ei2, eok);
        active = mask;
        start  = 1'b1;
        step();
        start = 1'b0;
        cyc   = 1;
        while (done !== 1'b1 && cyc < 30) begin
            chk({name, ".busy"}, 32'(busy), 32'd1);
            if (cyc <= N) chk({name, ".addr"}, 32'(addr), 32'(cyc - 1));
            if (disturb && cyc == 2) begin
                start  = 1'b1;
                active = ~mask;
            end
            if (disturb && cyc == 3) start = 1'b0;
            step();
            cyc++;
        end
        chk({name, ".latency"}, 32'(cyc), 32'(N + 2));
        chk({name, ".busy_done"}, 32'(busy), 32'd1);
        chk({name, ".mini1"}, 32'(mini1), 32'(em1));
        chk({name, ".idx1"}, 32'(idx1), 32'(ei1));
        chk({name, ".mini2"}, 32'(mini2), 32'(em2));
        chk({name, ".idx2"}, 32'(idx2), 32'(ei2));
        chk({name, ".pair_ok"}, 32'(pair_ok), 32'(eok));
        $display("scan %s mask=%b mini1=%0d idx1=%0d mini2=%0d idx2=%0d pair_ok=%0d",
                 name, mask, mini1, idx1, mini2, idx2, pair_ok);
        step();
        chk({name, ".done_pulse"}, 32'(done), 32'd0);
        chk({name, ".idle_busy"}, 32'(busy), 32'd0);
        chk({name, ".hold_mini1"}, 32'(mini1), 32'(em1));
    endtask

    task automatic load(input int c0, input int c1, input int c2, input int c3, input int c4, input int c5);
        mem[0] = 6'(c0); mem[1] = 6'(c1); mem[2] = 6'(c2);
        mem[3] = 6'(c3); mem[4] = 6'(c4); mem[5] = 6'(c5);
        mem[6] = '0;     mem[7] = '0;
    endtask

    task automatic chk_zero(input string name);
        chk({name, ".addr"}, 32'(addr), 32'd0);
        chk({name, ".mini1"}, 32'(mini1), 32'd0);
        chk({name, ".mini2"}, 32'(mini2), 32'd0);
        chk({name, ".idx1"}, 32'(idx1), 32'd0);
        chk({name, ".idx2"}, 32'(idx2), 32'd0);
        chk({name, ".flags"}, 32'({pair_ok, busy, done}), 32'd0);
    endtask

    initial begin
        int k;
        reset  = 1'b1;
        start  = 1'b0;
        active = '0;
        load(0, 0, 0, 0, 0, 0);
        step();
        step();
        chk_zero("reset");
        reset = 1'b0;
        step();

        load(9, 4, 7, 2, 8, 5);
        scan(6'b111111, 1'b0, "basic");
        load(3, 3, 1, 3, 1, 6);
        scan(6'b111011, 1'b0, "mask_ties");
        load(5, 7, 63, 1, 2, 3);
        scan(6'b000100, 1'b0, "single63");
        scan(6'b000000, 1'b0, "none");
        load(9, 4, 7, 2, 8, 5);
        scan(6'b101010, 1'b1, "ignored");
        load(1, 1, 1, 1, 1, 1);
        scan(6'b111111, 1'b0, "b2b_ones");
        load(63, 63, 62, 63, 63, 62);
        scan(6'b111111, 1'b0, "high_ties");

        // Reset in the middle of a scan.
        load(9, 4, 7, 2, 8, 5);
        active = 6'b111111;
        start  = 1'b1;
        step();
        start = 1'b0;
        k     = 0;
        while (addr !== 3'd3 && k < 10) begin
            step();
            k++;
        end
        chk("midrst.addr3", 32'(addr), 32'd3);
        chk("midrst.pre_mini1", 32'(mini1), 32'd4);
        reset = 1'b1;
        #1;
        chk_zero("midrst");
        step();
        reset = 1'b0;
        step();
        scan(6'b111111, 1'b0, "after_rst");

        for (int r = 0; r < 20; r++) begin
            for (int j = 0; j < 6; j++) mem[j] = 6'($urandom_range(0, (r % 3 == 0) ? 3 : 63));
            scan(6'($urandom), 1'b0, $sformatf("rnd%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
